// File: rtl/rf_nibble_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// rf_nibble_stream_ctrl_if
// Purpose : groups the requester, mux and nibble-output signals of the
//           nibble stream controller into one bundle.
// Signals :
//   req0_*/req1_*  valid/word/cnt from each requester, ready back to it
//   mux_D/mux_sel  latched word and nibble select driven to the 8-way mux
//   mux_Y          nibble returned by the mux (combinational)
//   out_*          nibble stream to the consumer (valid/ready, last, id)
//   busy           controller is streaming a word
// Modports:
//   master : requesters, mux and consumer side (the environment)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface rf_nibble_stream_ctrl_if #(
  parameter int DW = 32,
  parameter int SW = 3
);
  logic          req0_valid;
  logic [DW-1:0] req0_word;
  logic [SW-1:0] req0_cnt;
  logic          req0_ready;

  logic          req1_valid;
  logic [DW-1:0] req1_word;
  logic [SW-1:0] req1_cnt;
  logic          req1_ready;

  logic [DW-1:0] mux_D;
  logic [SW-1:0] mux_sel;
  logic [3:0]    mux_Y;

  logic          out_valid;
  logic [3:0]    out_nib;
  logic          out_last;
  logic          out_id;
  logic          out_ready;
  logic          busy;

  modport master (
    output req0_valid, req0_word, req0_cnt,
    output req1_valid, req1_word, req1_cnt,
    output mux_Y, out_ready,
    input  req0_ready, req1_ready,
    input  mux_D, mux_sel,
    input  out_valid, out_nib, out_last, out_id, busy
  );

  modport slave (
    input  req0_valid, req0_word, req0_cnt,
    input  req1_valid, req1_word, req1_cnt,
    input  mux_Y, out_ready,
    output req0_ready, req1_ready,
    output mux_D, mux_sel,
    output out_valid, out_nib, out_last, out_id, busy
  );
endinterface

// File: rtl/rf_nibble_stream_ctrl.sv
// ---------------------------------------------------------------------------
// rf_nibble_stream_ctrl
// Purpose : shares one 8-way nibble read mux between two requesters.
//           A granted 32-bit word is latched onto mux_D and mux_sel is
//           stepped from 0 up to the requested count, streaming nibbles
//           LSB-first to the consumer under valid/ready flow control.
//           Arbitration between the two requesters is round-robin.
// Ports   :
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    rf_nibble_stream_ctrl_if.slave (requesters, mux, output stream)
// ---------------------------------------------------------------------------
module rf_nibble_stream_ctrl #(
  parameter int DW = 32,
  parameter int SW = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rf_nibble_stream_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Registered state
  state_t        state_reg;
  logic [DW-1:0] mux_d_reg;
  logic [SW-1:0] mux_sel_reg;
  logic [SW-1:0] cnt_reg;
  logic          out_id_reg;
  logic          last_grant_reg;

  // Requester views as arrays so both sides share one grant path
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req_word [2];
  logic [SW-1:0] req_cnt  [2];

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign req_word[0] = bus.req0_word;
  assign req_word[1] = bus.req1_word;
  assign req_cnt[0]  = bus.req0_cnt;
  assign req_cnt[1]  = bus.req1_cnt;

  // Grant decode: only meaningful in IDLE. With both requesting, the one
  // that did not win last time goes; last_grant resets to 1 so req0 wins
  // the first contested grant.
  logic grant_valid;
  logic grant_id;
  logic is_last;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_reg == IDLE) begin
      grant_valid = |req_valid;
      if (&req_valid) begin
        grant_id = ~last_grant_reg;
      end else begin
        grant_id = req_valid[1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = grant_valid && (grant_id == 1'(gi));
    end
  endgenerate

  // mux_sel never passes cnt_reg, so the select never wraps.
  assign is_last = (mux_sel_reg == cnt_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      mux_d_reg      <= '0;
      mux_sel_reg    <= '0;
      cnt_reg        <= '0;
      out_id_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            mux_d_reg      <= req_word[grant_id];
            cnt_reg        <= req_cnt[grant_id];
            out_id_reg     <= grant_id;
            last_grant_reg <= grant_id;
            mux_sel_reg    <= '0;
            state_reg      <= STREAM;
          end
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (is_last) begin
              // mux_D is left holding the finished word
              mux_sel_reg <= '0;
              state_reg   <= IDLE;
            end else begin
              mux_sel_reg <= mux_sel_reg + SW'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Outputs
  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign bus.mux_D      = mux_d_reg;
  assign bus.mux_sel    = mux_sel_reg;
  assign bus.out_valid  = (state_reg == STREAM);
  assign bus.busy       = (state_reg == STREAM);
  assign bus.out_nib    = bus.mux_Y;
  assign bus.out_last   = (state_reg == STREAM) && is_last;
  assign bus.out_id     = out_id_reg;

endmodule

// File: tb/tb_rf_nibble_stream_ctrl.sv
module tb_rf_nibble_stream_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  rf_nibble_stream_ctrl_if #(.DW(32), .SW(3)) bus ();

  rf_nibble_stream_ctrl #(.DW(32), .SW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 8-way nibble mux
  assign bus.mux_Y = bus.mux_D[{bus.mux_sel, 2'b00} +: 4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expected output beats produced by the reference model
  typedef struct {
    logic [3:0]  nib;
    logic        last;
    logic        id;
    int          idx;
    logic [31:0] word;
  } beat_t;

  beat_t sb_q[$];

  // Reference model: transaction-level view of the arbiter. Every cycle it
  // decides whether a grant happens, and on a grant queues the nibbles the
  // word must produce. Sampled 2 time units after the falling edge.
  initial begin : model
    int          m_left;
    logic        m_last;
    logic        m_id;
    logic [31:0] m_word;
    logic        g_any;
    logic        g;
    logic [31:0] w;
    int          c;
    beat_t       b;
    m_left = 0; m_last = 1'b1; m_id = 1'b0; m_word = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        sb_q.delete();
        m_left = 0; m_last = 1'b1; m_id = 1'b0; m_word = '0;
        continue;
      end
      if (m_left == 0) begin
        g_any = bus.req0_valid || bus.req1_valid;
        g     = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_out_last", 32'(bus.out_last), 0);
        chk("idle_mux_sel", 32'(bus.mux_sel), 0);
        chk("idle_mux_D", bus.mux_D, m_word);
        chk("idle_out_id", 32'(bus.out_id), 32'(m_id));
        chk("req0_ready", 32'(bus.req0_ready), 32'(g_any && !g));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g_any && g));
        if (g_any) begin
          w = g ? bus.req1_word : bus.req0_word;
          c = g ? int'(bus.req1_cnt) : int'(bus.req0_cnt);
          for (int i = 0; i <= c; i++) begin
            b.nib  = 4'((w >> (4 * i)) & 32'hF);
            b.last = (i == c);
            b.id   = g;
            b.idx  = i;
            b.word = w;
            sb_q.push_back(b);
          end
          m_left = c + 1;
          m_last = g;
          m_id   = g;
          m_word = w;
        end
      end else begin
        chk("stream_busy", 32'(bus.busy), 1);
        chk("stream_req0_ready", 32'(bus.req0_ready), 0);
        chk("stream_req1_ready", 32'(bus.req1_ready), 0);
        if (bus.out_ready) m_left--;
      end
    end
  end

  // Monitor: whenever the DUT presents a nibble, compare it with the head of
  // the scoreboard; pop only when the consumer accepts it.
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) continue;
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 0);
        end else begin
          b = sb_q[0];
          chk("out_nib", 32'(bus.out_nib), 32'(b.nib));
          chk("out_last", 32'(bus.out_last), 32'(b.last));
          chk("out_id", 32'(bus.out_id), 32'(b.id));
          chk("mux_sel", 32'(bus.mux_sel), 32'(b.idx));
          chk("mux_D", bus.mux_D, b.word);
          if (bus.out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers (all start/end just after negedge) ----
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input bit id, input logic [31:0] w, input logic [2:0] c);
    bit hs;
    hs = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_word = w; bus.req1_cnt = c;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_word = w; bus.req0_cnt = c;
    end
    for (int k = 0; k < 50 && !hs; k++) begin
      #2;
      hs = id ? bus.req1_ready : bus.req0_ready;
      @(negedge clk);
    end
    // Scramble the word after handshake; the latched copy must not follow.
    if (id) begin
      bus.req1_valid = 1'b0; bus.req1_word = $urandom; bus.req1_cnt = 3'($urandom);
    end else begin
      bus.req0_valid = 1'b0; bus.req0_word = $urandom; bus.req0_cnt = 3'($urandom);
    end
    chk("handshake_seen", 32'(hs), 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      #2;
      done = !bus.busy;
      @(negedge clk);
    end
    chk("idle_reached", 32'(done), 1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin : stim
    int  grants[$];
    int  gcyc[$];
    bit  hs0, hs1, r0, r1;
    cyc = 0; n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_word = '0; bus.req0_cnt = '0;
    bus.req1_valid = 1'b0; bus.req1_word = '0; bus.req1_cnt = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single full word from req0
    send(1'b0, 32'h8765_4321, 3'd7);
    wait_idle();

    // Short word from req1
    send(1'b1, 32'hDEAD_BEEF, 3'd2);
    wait_idle();

    // Back-pressure at mux_sel=1
    send(1'b0, 32'h0000_A5C3, 3'd3);
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("bp_mux_sel", 32'(bus.mux_sel), 1);
      chk("bp_out_nib", 32'(bus.out_nib), 32'hC);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_idle();

    // Reset mid-stream at mux_sel=4
    send(1'b0, $urandom, 3'd7);
    repeat (4) @(negedge clk);
    #2;
    chk("pre_reset_mux_sel", 32'(bus.mux_sel), 4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 32'h1357_9BDF, 3'd5);
    wait_idle();

    // Request from req1 raised while req0 streams
    send(1'b0, $urandom, 3'd7);
    send(1'b1, $urandom, 3'd3);
    wait_idle();

    // Round-robin with both requesters always valid, cnt=0
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_word = $urandom; bus.req0_cnt = 3'd0;
    bus.req1_valid = 1'b1; bus.req1_word = $urandom; bus.req1_cnt = 3'd0;
    for (int k = 0; k < 40 && grants.size() < 8; k++) begin
      #2;
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      if (r0) begin grants.push_back(0); gcyc.push_back(cyc); end
      if (r1) begin grants.push_back(1); gcyc.push_back(cyc); end
      @(negedge clk);
      if (r0) bus.req0_word = $urandom;
      if (r1) bus.req1_word = $urandom;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_grant_count", 32'(grants.size()), 8);
    for (int i = 0; i < grants.size(); i++) begin
      chk("rr_grant_order", 32'(grants[i]), 32'(i % 2));
      if (i > 0) chk("rr_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 2);
    end
    wait_idle();

    // Randomised traffic with random back-pressure
    hs0 = 1'b0; hs1 = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (hs0) begin
        bus.req0_valid = 1'b0; bus.req0_word = $urandom; bus.req0_cnt = 3'($urandom);
      end
      if (hs1) begin
        bus.req1_valid = 1'b0; bus.req1_word = $urandom; bus.req1_cnt = 3'($urandom);
      end
      if (!bus.req0_valid && $urandom_range(0, 3) == 0) begin
        bus.req0_valid = 1'b1; bus.req0_word = $urandom; bus.req0_cnt = 3'($urandom);
      end
      if (!bus.req1_valid && $urandom_range(0, 3) == 0) begin
        bus.req1_valid = 1'b1; bus.req1_word = $urandom; bus.req1_cnt = 3'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #2;
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
